// File: rtl/mux2_1_rr_arbiter_if.sv
// Handshake and result bundle between the two requesters and the round-robin
// arbiter that owns the shared registered 2:1 mux.
interface mux2_1_rr_arbiter_if #(
  parameter int CNT_W = 7
);
  logic             valid0;
  logic [1:0]       data_in0;
  logic             ready0;
  logic             valid1;
  logic [1:0]       data_in1;
  logic             ready1;
  logic             selector;
  logic [1:0]       data_out;
  logic             valid_out;
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;

  modport master (
    output valid0, data_in0, valid1, data_in1,
    input  ready0, ready1, selector, data_out, valid_out, grant_cnt0, grant_cnt1
  );

  modport slave (
    input  valid0, data_in0, valid1, data_in1,
    output ready0, ready1, selector, data_out, valid_out, grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/mux2_1_rr_arbiter.sv
// Round-robin arbiter driving the registered 2:1 mux and per-port transfer counters.
// Define ARB_BURST_EN to let a granted port keep the grant for up to BURST_MAX beats.
module mux2_1_rr_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 7
) (
  input  logic               clk,
  input  logic               reset_L,
  mux2_1_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_burst_range
    $error("BURST_MAX must be in 1..15");
  end

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic             take;
  logic             take_port;
  logic [1:0]       data_p0;
  logic             sel_p0;
  logic             vld_p0;
  logic [CNT_W-1:0] cnt0_p0;
  logic [CNT_W-1:0] cnt1_p0;

  // lst is the most recently granted port; on a tie the other port wins
  function automatic state_t arbitrate(input logic v0, input logic v1, input logic lst);
    if (v0 && v1)
      return lst ? GRANT0 : GRANT1;
    else if (v0)
      return GRANT0;
    else if (v1)
      return GRANT1;
    else
      return IDLE;
  endfunction

  assign take      = ((state == GRANT0) && bus.valid0) || ((state == GRANT1) && bus.valid1);
  assign take_port = (state == GRANT1);

`ifdef ARB_BURST_EN
  localparam logic [3:0] BEAT_LAST = 4'(BURST_MAX - 1);

  logic [3:0] beat_cnt;
  logic       hold;

  assign hold = take && (beat_cnt < BEAT_LAST);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)
      beat_cnt <= 4'd0;
    else
      beat_cnt <= hold ? beat_cnt + 4'd1 : 4'd0;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = arbitrate(bus.valid0, bus.valid1, last);
      GRANT0:  state_nxt = arbitrate(bus.valid0, bus.valid1, 1'b0);
      GRANT1:  state_nxt = arbitrate(bus.valid0, bus.valid1, 1'b1);
      default: state_nxt = IDLE;
    endcase
`ifdef ARB_BURST_EN
    if (hold)
      state_nxt = state;
`endif
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (take)
        last <= take_port;
    end
  end

  // Stage p0: registered mux output and transfer counters
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_p0 <= 2'b00;
      sel_p0  <= 1'b0;
      vld_p0  <= 1'b0;
      cnt0_p0 <= '0;
      cnt1_p0 <= '0;
    end else begin
      vld_p0 <= take;
      if (take) begin
        data_p0 <= take_port ? bus.data_in1 : bus.data_in0;
        sel_p0  <= take_port;
        if (take_port)
          cnt1_p0 <= cnt1_p0 + {{(CNT_W-1){1'b0}}, 1'b1};
        else
          cnt0_p0 <= cnt0_p0 + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.ready0     = (state == GRANT0);
  assign bus.ready1     = (state == GRANT1);
  assign bus.selector   = sel_p0;
  assign bus.data_out   = data_p0;
  assign bus.valid_out  = vld_p0;
  assign bus.grant_cnt0 = cnt0_p0;
  assign bus.grant_cnt1 = cnt1_p0;

endmodule

// File: tb/tb_mux2_1_rr_arbiter.sv
// Directed and random checks of mux2_1_rr_arbiter against a grant-owner model
// that follows the arbitration rules at transaction level.
module tb_mux2_1_rr_arbiter;

  localparam int CNT_W     = 7;
  localparam int BURST_MAX = 4;
  localparam int CNT_MOD   = 1 << CNT_W;
`ifdef ARB_BURST_EN
  localparam int BURST_LEN = BURST_MAX;
`else
  localparam int BURST_LEN = 1;
`endif

  logic clk = 1'b0;
  logic reset_L;

  always #5 clk = ~clk;

  mux2_1_rr_arbiter_if #(.CNT_W(CNT_W)) bus ();

  mux2_1_rr_arbiter #(.BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference: who holds the grant (-1 none), last winner, beats in current grant
  int         owner;
  int         m_last;
  int         m_beats;
  logic [1:0] m_dout;
  logic       m_sel;
  logic       m_vout;
  int         m_cnt [2];

  function automatic int pick(input bit v0, input bit v1, input int pref);
    if (v0 && v1) return pref;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    owner    = -1;
    m_last   = 1;
    m_beats  = 0;
    m_dout   = 2'b00;
    m_sel    = 1'b0;
    m_vout   = 1'b0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic model_edge();
    bit         v [2];
    logic [1:0] d [2];
    v[0] = bus.valid0;
    v[1] = bus.valid1;
    d[0] = bus.data_in0;
    d[1] = bus.data_in1;
    if (owner < 0) begin
      m_vout  = 1'b0;
      owner   = pick(v[0], v[1], 1 - m_last);
      m_beats = 0;
    end else if (v[owner]) begin
      m_dout        = d[owner];
      m_sel         = (owner == 1);
      m_vout        = 1'b1;
      m_cnt[owner]  = (m_cnt[owner] + 1) % CNT_MOD;
      m_last        = owner;
      m_beats       = m_beats + 1;
      if (m_beats >= BURST_LEN) begin
        owner   = pick(v[0], v[1], 1 - m_last);
        m_beats = 0;
      end
    end else begin
      m_vout  = 1'b0;
      owner   = pick(v[0], v[1], 1 - owner);
      m_beats = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ready0"},     32'(bus.ready0),     32'(owner == 0));
    chk({tag, ".ready1"},     32'(bus.ready1),     32'(owner == 1));
    chk({tag, ".selector"},   32'(bus.selector),   32'(m_sel));
    chk({tag, ".data_out"},   32'(bus.data_out),   32'(m_dout));
    chk({tag, ".valid_out"},  32'(bus.valid_out),  32'(m_vout));
    chk({tag, ".grant_cnt0"}, 32'(bus.grant_cnt0), 32'(m_cnt[0]));
    chk({tag, ".grant_cnt1"}, 32'(bus.grant_cnt1), 32'(m_cnt[1]));
  endtask

  task automatic cyc(input bit v0, input logic [1:0] d0, input bit v1, input logic [1:0] d1,
                     input string tag);
    @(negedge clk);
    bus.valid0   = v0;
    bus.data_in0 = d0;
    bus.valid1   = v1;
    bus.data_in1 = d1;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset_L      = 1'b0;
    bus.valid0   = 1'b0;
    bus.valid1   = 1'b0;
    bus.data_in0 = 2'b00;
    bus.data_in1 = 2'b00;
    model_reset();
    #1;
    check_outputs(tag);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] held;
    int         exp_port;
    int         diff;

    reset_L      = 1'b0;
    bus.valid0   = 1'b0;
    bus.valid1   = 1'b0;
    bus.data_in0 = 2'b00;
    bus.data_in1 = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("por");
    reset_L = 1'b1;

    // Single port from IDLE
    cyc(1'b1, 2'b10, 1'b0, 2'b00, "single_e1");
    chk("single_ready0", 32'(bus.ready0), 32'd1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 2'b10, 1'b0, 2'b00, "single");
      chk("single_dout", 32'(bus.data_out), 32'd2);
      chk("single_vout", 32'(bus.valid_out), 32'd1);
      chk("single_sel", 32'(bus.selector), 32'd0);
    end

    // Reset while port 0 is mid-stream, then both ports valid
    do_reset("mid_reset");
    chk("mid_reset_cnt0", 32'(bus.grant_cnt0), 32'd0);
    cyc(1'b1, 2'b01, 1'b1, 2'b10, "both_e1");
    chk("both_ready0_first", 32'(bus.ready0), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 2'b01, 1'b1, 2'b10, "alt");
      exp_port = (i / BURST_LEN) % 2;
      chk("alt_sel", 32'(bus.selector), 32'(exp_port));
      chk("alt_dout", 32'(bus.data_out), (exp_port == 1) ? 32'd2 : 32'd1);
      diff = int'(bus.grant_cnt0) - int'(bus.grant_cnt1);
      chk("alt_balance", 32'(diff <= BURST_LEN && diff >= -BURST_LEN), 32'd1);
    end

    // Idle beat: port 0 drops valid while it holds the grant
    for (int k = 0; k < 2 * BURST_LEN + 2 && owner != 0; k++)
      cyc(1'b1, 2'b01, 1'b1, 2'b10, "seek_g0");
    chk("reach_grant0", 32'(bus.ready0), 32'd1);
    held = m_dout;
    cyc(1'b0, 2'b11, 1'b1, 2'b10, "idle_beat");
    chk("idle_vout", 32'(bus.valid_out), 32'd0);
    chk("idle_hold", 32'(bus.data_out), 32'(held));
    chk("idle_then_grant1", 32'(bus.ready1), 32'd1);
    cyc(1'b0, 2'b11, 1'b1, 2'b10, "after_idle");
    chk("after_idle_dout", 32'(bus.data_out), 32'd2);
    chk("after_idle_sel", 32'(bus.selector), 32'd1);

    // Counter wrap on port 0 with a non-zero port 1 count
    do_reset("wrap_reset");
    repeat (3) cyc(1'b0, 2'b00, 1'b1, 2'b01, "wrap_p1");
    chk("wrap_cnt1_pre", 32'(bus.grant_cnt1), 32'd2);
    cyc(1'b1, 2'b11, 1'b0, 2'b00, "wrap_switch");
    for (int i = 0; i < CNT_MOD - 1; i++)
      cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 2'b00, "wrap");
    chk("wrap_cnt0_max", 32'(bus.grant_cnt0), 32'(CNT_MOD - 1));
    cyc(1'b1, 2'b01, 1'b0, 2'b00, "wrap_last");
    chk("wrap_cnt0_zero", 32'(bus.grant_cnt0), 32'd0);
    chk("wrap_cnt1_kept", 32'(bus.grant_cnt1), 32'd2);

    // Random traffic with data changes while waiting for a grant
    do_reset("rand_reset");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("rand_mid_reset");
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
